// File: rtl/dcache.sv
// Direct-mapped write-back, write-allocate data cache between the CPU load/store port
// and a 256-bit line memory. One completion pulse per request; loads return data with it.
module dcache #(
  parameter int unsigned NUM_SETS = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mem_read_i,
  input  logic         mem_write_i,
  input  logic [31:0]  mem_addr_i,
  input  logic [31:0]  mem_data_i,
  input  logic [3:0]   mem_byte_en_i,
  output logic         mem_resp_o,
  output logic [31:0]  mem_data_o,
  output logic         pmem_read_o,
  output logic         pmem_write_o,
  output logic [31:0]  pmem_addr_o,
  output logic [255:0] pmem_wdata_o,
  input  logic [255:0] pmem_rdata_i,
  input  logic         pmem_resp_i
);

  localparam int unsigned IdxW = $clog2(NUM_SETS);
  localparam int unsigned TagW = 32 - 5 - IdxW;

  typedef enum logic [1:0] {StIdle, StResp, StWb, StFill} state_e;

  state_e              r_state;
  logic [NUM_SETS-1:0] r_valid;
  logic [NUM_SETS-1:0] r_dirty;
  logic [TagW-1:0]     r_tag  [NUM_SETS];
  logic [255:0]        r_data [NUM_SETS];
  logic [31:5]         r_addr;
  logic                r_resp;
  logic [31:0]         r_rdata;

  logic [IdxW-1:0] w_idx;
  logic [TagW-1:0] w_tag;
  logic [2:0]      w_off;
  logic            w_req;
  logic            w_hit;
  logic [31:0]     w_word;
  logic [IdxW-1:0] w_ridx;
  logic [TagW-1:0] w_rtag;
  logic            w_store_hit;
  logic            w_fill_done;
  logic [1:0]      w_unused_addr;

  assign w_idx         = mem_addr_i[IdxW+4:5];
  assign w_tag         = mem_addr_i[31:IdxW+5];
  assign w_off         = mem_addr_i[4:2];
  assign w_req         = mem_read_i | mem_write_i;
  assign w_hit         = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_word        = r_data[w_idx][{w_off, 5'b00000} +: 32];
  assign w_unused_addr = mem_addr_i[1:0];

  // Miss handling works from the captured address so pmem outputs never see mem_*_i.
  assign w_ridx = r_addr[IdxW+4:5];
  assign w_rtag = r_addr[31:IdxW+5];

  assign w_store_hit = (r_state == StIdle) && mem_write_i && w_hit;
  assign w_fill_done = (r_state == StFill) && pmem_resp_i;

  assign mem_resp_o = r_resp;
  assign mem_data_o = r_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_valid <= '0;
      r_dirty <= '0;
      r_addr  <= '0;
      r_resp  <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_resp <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_req) begin
            r_addr <= mem_addr_i[31:5];
            if (w_hit) begin
              r_state <= StResp;
              r_resp  <= 1'b1;
              if (mem_write_i) begin
                r_dirty[w_idx] <= 1'b1;
              end else begin
                r_rdata <= w_word;
              end
            end else if (r_valid[w_idx] && r_dirty[w_idx]) begin
              r_state <= StWb;
            end else begin
              r_state <= StFill;
            end
          end
        end
        StResp: r_state <= StIdle;
        StWb: begin
          if (pmem_resp_i) begin
            r_dirty[w_ridx] <= 1'b0;
            r_state         <= StFill;
          end
        end
        StFill: begin
          if (pmem_resp_i) begin
            r_valid[w_ridx] <= 1'b1;
            r_dirty[w_ridx] <= 1'b0;
            r_state         <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Tag and line storage carry no reset; validity alone qualifies them.
  always_ff @(posedge clk) begin
    if (w_fill_done) begin
      r_data[w_ridx] <= pmem_rdata_i;
      r_tag[w_ridx]  <= w_rtag;
    end else if (w_store_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_byte_en_i[b[1:0]]) begin
          r_data[w_idx][{w_off, b[1:0], 3'b000} +: 8] <= mem_data_i[{b[1:0], 3'b000} +: 8];
        end
      end
    end
  end

  always_comb begin
    pmem_read_o  = 1'b0;
    pmem_write_o = 1'b0;
    pmem_addr_o  = '0;
    pmem_wdata_o = '0;
    unique case (r_state)
      StWb: begin
        pmem_write_o = 1'b1;
        pmem_addr_o  = {r_tag[w_ridx], w_ridx, 5'b00000};
        pmem_wdata_o = r_data[w_ridx];
      end
      StFill: begin
        pmem_read_o = 1'b1;
        pmem_addr_o = {w_rtag, w_ridx, 5'b00000};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dcache.sv
// Bench for dcache: directed scenarios then random loads/stores against a word-level memory
// model with a separate backing store and per-set residency bookkeeping.
module tb_dcache;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         mem_read_i = 1'b0;
  logic         mem_write_i = 1'b0;
  logic [31:0]  mem_addr_i = '0;
  logic [31:0]  mem_data_i = '0;
  logic [3:0]   mem_byte_en_i = '0;
  logic         mem_resp_o;
  logic [31:0]  mem_data_o;
  logic         pmem_read_o;
  logic         pmem_write_o;
  logic [31:0]  pmem_addr_o;
  logic [255:0] pmem_wdata_o;
  logic [255:0] pmem_rdata_i = '0;
  logic         pmem_resp_i = 1'b0;

  dcache #(.NUM_SETS(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_read_i   (mem_read_i),
    .mem_write_i  (mem_write_i),
    .mem_addr_i   (mem_addr_i),
    .mem_data_i   (mem_data_i),
    .mem_byte_en_i(mem_byte_en_i),
    .mem_resp_o   (mem_resp_o),
    .mem_data_o   (mem_data_o),
    .pmem_read_o  (pmem_read_o),
    .pmem_write_o (pmem_write_o),
    .pmem_addr_o  (pmem_addr_o),
    .pmem_wdata_o (pmem_wdata_o),
    .pmem_rdata_i (pmem_rdata_i),
    .pmem_resp_i  (pmem_resp_i)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;

  // CPU-visible memory, lower-memory contents, and which line each set holds (4 KiB space).
  logic [31:0] golden  [1024];
  logic [31:0] backing [1024];
  bit          res_valid [8];
  bit          res_dirty [8];
  int          res_tag   [8];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] line_of(input bit from_golden, input int byte_addr);
    logic [255:0] l;
    int base;
    base = (byte_addr % 4096) / 4 & ~7;
    for (int i = 0; i < 8; i++) begin
      l[32*i +: 32] = from_golden ? golden[base + i] : backing[base + i];
    end
    return l;
  endfunction

  task automatic do_req(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] be, input int dly);
    int  set, tag, wb_start, fill_start, wresp, fresp, widx;
    bit  exp_hit, exp_wb, got;
    logic [31:0] nw;
    @(posedge clk); #1;
    chk("resp_single", mem_resp_o, 1'b0);
    set     = int'(addr[7:5]);
    tag     = int'(addr[31:8]);
    widx    = int'(addr[11:2]);
    exp_hit = res_valid[set] && res_tag[set] == tag;
    exp_wb  = !exp_hit && res_valid[set] && res_dirty[set];
    mem_read_i    = !wr;
    mem_write_i   = wr;
    mem_addr_i    = addr;
    mem_data_i    = data;
    mem_byte_en_i = be;
    wb_start = -1; fill_start = -1; wresp = -1; fresp = -1; got = 0;
    for (int cyc = 1; cyc <= 100 && !got; cyc++) begin
      @(posedge clk); #1;
      pmem_resp_i  = 1'b0;
      pmem_rdata_i = {8{$urandom()}};
      if (pmem_read_o && pmem_write_o) chk("pmem_both", 1'b1, 1'b0);
      if (pmem_write_o && wb_start < 0) begin
        wb_start = cyc;
        chk("wb_expected", 1'b1, exp_wb);
        chk("wb_start", cyc, 1);
        chk("wb_addr", pmem_addr_o, res_tag[set] * 256 + set * 32);
        chk("wb_data", pmem_wdata_o, line_of(1, res_tag[set] * 256 + set * 32));
      end
      if (pmem_read_o && fill_start < 0) begin
        fill_start = cyc;
        chk("fill_expected", 1'b1, !exp_hit);
        chk("fill_start", cyc, exp_wb ? wresp + 1 : 1);
        chk("fill_addr", pmem_addr_o, {addr[31:5], 5'b00000});
      end
      if (pmem_write_o && cyc == wb_start + dly) begin
        pmem_resp_i = 1'b1;
        wresp = cyc;
      end
      if (pmem_read_o && cyc == fill_start + dly) begin
        pmem_resp_i  = 1'b1;
        pmem_rdata_i = line_of(0, int'(addr));
        fresp = cyc;
      end
      if (mem_resp_o) begin
        got = 1;
        chk("resp_latency", cyc, exp_hit ? 1 : fresp + 2);
        if (!wr) chk("load_data", mem_data_o, golden[widx]);
      end
    end
    if (!got) chk("resp_timeout", 1'b0, 1'b1);
    mem_read_i  = 1'b0;
    mem_write_i = 1'b0;
    if (exp_wb) begin
      for (int i = 0; i < 8; i++) begin
        backing[(res_tag[set] * 256 + set * 32) / 4 + i] =
          golden[(res_tag[set] * 256 + set * 32) / 4 + i];
      end
    end
    if (!exp_hit) begin
      res_valid[set] = 1;
      res_dirty[set] = 0;
      res_tag[set]   = tag;
    end
    if (wr) begin
      nw = golden[widx];
      for (int b = 0; b < 4; b++) if (be[b]) nw[8*b +: 8] = data[8*b +: 8];
      golden[widx]   = nw;
      res_dirty[set] = 1;
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      backing[i] = (i * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
      golden[i]  = backing[i];
    end
    for (int s = 0; s < 8; s++) begin
      res_valid[s] = 0; res_dirty[s] = 0; res_tag[s] = 0;
    end
    backing[32'h100 / 4] = 32'hDEAD_BEEF;
    golden[32'h100 / 4]  = 32'hDEAD_BEEF;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_resp", mem_resp_o, 1'b0);
    chk("rst_rdata", mem_data_o, 32'h0);
    chk("rst_pread", pmem_read_o, 1'b0);
    chk("rst_pwrite", pmem_write_o, 1'b0);
    chk("rst_paddr", pmem_addr_o, 32'h0);
    chk("rst_pwdata", pmem_wdata_o, 256'h0);
    rst = 1'b0;

    do_req(0, 32'h100, '0, 4'h0, 3);
    do_req(0, 32'h104, '0, 4'h0, 3);
    do_req(1, 32'h104, 32'h00AB_0000, 4'b0100, 3);
    do_req(0, 32'h104, '0, 4'h0, 3);
    chk("byte_merge", golden[32'h104 / 4], {backing[32'h104 / 4][31:24], 8'hAB,
                                           backing[32'h104 / 4][15:0]});
    do_req(0, 32'h200, '0, 4'h0, 2);
    do_req(0, 32'h204, '0, 4'h0, 1);
    do_req(0, 32'h2E8, '0, 4'h0, 0);
    do_req(1, 32'h2EA, 32'h1234_5678, 4'b1111, 2);
    do_req(0, 32'h2E9, '0, 4'h0, 2);

    // Abort an in-flight fill with reset; the cache must forget everything.
    @(posedge clk); #1;
    mem_read_i = 1'b1;
    mem_addr_i = 32'hE0C;
    for (int i = 0; i < 10 && !pmem_read_o; i++) begin
      @(posedge clk); #1;
    end
    chk("pre_rst_fill", pmem_read_o, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("rst_drop_read", pmem_read_o, 1'b0);
    chk("rst_drop_addr", pmem_addr_o, 32'h0);
    chk("rst_drop_resp", mem_resp_o, 1'b0);
    mem_read_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int s = 0; s < 8; s++) begin
      res_valid[s] = 0; res_dirty[s] = 0;
    end
    for (int i = 0; i < 1024; i++) golden[i] = backing[i];
    do_req(0, 32'h100, '0, 4'h0, 1);

    for (int n = 0; n < 200; n++) begin
      do_req(1'($urandom_range(0, 1)), 32'($urandom_range(0, 4095)), $urandom(),
             4'($urandom_range(0, 15)), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/dcache.md
# dcache

Direct-mapped, write-back, write-allocate data cache answering the word-level load/store request protocol issued by the CPU's data interface. It sits between the load/store path (CPU side: `mem_read`/`mem_write`/`mem_resp`, 32-bit word with byte enables) and physical memory (256-bit line bursts with `pmem_resp`). It is the responder for that protocol: exactly one single-cycle `mem_resp_o` per request, with read data valid in the same cycle.

## Interface
- `NUM_SETS`, 8, number of lines; power of two, ≥2. Index = `addr[4+log2(NUM_SETS):5]`, offset = `addr[4:0]`, tag = remaining upper bits.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `mem_read_i`  in  1  load request; held with address until `mem_resp_o`.
- `mem_write_i`  in  1  store request; held with address/data/byte enables until `mem_resp_o`.
- `mem_addr_i`  in  32  word address; bits [1:0] are ignored.
- `mem_data_i`  in  32  store data, already lane-shifted by the requester.
- `mem_byte_en_i`  in  4  store byte lanes; ignored for loads.
- `mem_resp_o`  out  1  one-cycle completion pulse.
- `mem_data_o`  out  32  full aligned word for loads; valid while `mem_resp_o`=1.
- `pmem_read_o`  out  1  line fill request.
- `pmem_write_o`  out  1  line writeback request.
- `pmem_addr_o`  out  32  line address, bits [4:0]=0.
- `pmem_wdata_o`  out  256  writeback line.
- `pmem_rdata_i`  in  256  fill line, sampled when `pmem_resp_i`=1 during a fill.
- `pmem_resp_i`  in  1  lower-memory completion pulse.

## Operation
- Per set: valid bit, dirty bit, tag, 256-bit line, all flops. Valid and dirty cleared by reset; tags/data not reset.
- States: IDLE, RESP, WB, FILL.
- IDLE: no request → stay. Request (`mem_write_i` has priority if both asserted) and hit → go RESP; on the same edge, a load registers the addressed word into `mem_data_o`, and a store writes the enabled bytes into the line and sets dirty. Miss with victim valid and dirty → WB. Otherwise miss → FILL.
- WB: `pmem_write_o`=1, `pmem_addr_o`={victim tag, index, 5'b0}, `pmem_wdata_o`=victim line, all held stable. On `pmem_resp_i` → FILL and clear dirty.
- FILL: `pmem_read_o`=1, `pmem_addr_o`={req tag, index, 5'b0}. On `pmem_resp_i` → install `pmem_rdata_i`, set valid, clear dirty, set tag → IDLE. IDLE then re-evaluates the request, which hits.
- RESP: `mem_resp_o`=1 for exactly one cycle → IDLE. The request still visible during RESP is never re-evaluated.
- Write miss: allocate (fill) first, then merge the store on the hit pass.
- `pmem_read_o` and `pmem_write_o` are never both 1.

## Timing
- Reset: state IDLE. Every output is 0: `mem_resp_o`, `mem_data_o`, `pmem_read_o`, `pmem_write_o`, `pmem_addr_o`, `pmem_wdata_o`. All lines are invalid. Reset asserted mid-WB/FILL drops pmem requests immediately (asynchronously); dirty data is lost.
- Hit: request first seen in cycle t → `mem_resp_o` in t+1 → IDLE in t+2. A new request may be presented in t+2, giving one request every 2 cycles.
- Clean miss: request in t → `pmem_read_o` from t+1. `pmem_resp_i` at cycle f → IDLE at f+1 → `mem_resp_o` at f+2.
- Dirty miss: WB from t+1 until `pmem_resp_i` at w. FILL then runs from w+1, followed by the same tail as a clean miss.
- `pmem_*` outputs are combinational from state and registered array contents only; no combinational path from `mem_*_i` to `pmem_*_o` or `mem_resp_o`.
- `mem_data_o` holds its last value outside RESP (not required to be 0 after reset-clear).

## Test plan
- Reset, then load 0x0000_0100. Expect `pmem_read_o`=1 with `pmem_addr_o`=0x100 from the next cycle. Return a line with word0=0xDEADBEEF after 3 cycles. Expect exactly one `mem_resp_o` 2 cycles after `pmem_resp_i`, with `mem_data_o`=0xDEADBEEF.
- Load 0x104 on the resident line. Expect `mem_resp_o` the next cycle with word1 of the line, and no `pmem_*` activity.
- Store 0x00AB_0000 to 0x104 with `byte_en`=4'b0100 (hit). Expect resp at t+1. A later load of 0x104 returns byte2=0xAB with the other bytes unchanged, and the set is dirty.
- With `NUM_SETS`=8 and 0x100 dirty, load 0x200 (same index 0). Expect `pmem_write_o` at address 0x100 with the modified line, then `pmem_read_o` at 0x200, then the resp. No cycle has both pmem requests asserted.
- Issue back-to-back requests with a new one presented the cycle after each resp: hit, miss, store hit, load. Expect exactly one resp per request, in order, with correct data.
- Assert `rst` mid-FILL. Expect `pmem_read_o` to drop in the same cycle. After release, a load of 0x100 misses again.
